// File: rtl/btn_event_decoder.sv
// Button event decoder: classifies a debounced button level into short/long/repeat(/double) pulses.
// Latency: event pulses are registered, 1 cycle after the deciding sample; o_hold decodes the state register.
// Backpressure: none; i_btn is sampled every cycle and pulses are fire-and-forget. Optional double click via BTN_DCLICK_EN.
module btn_event_decoder #(
    parameter int TICK_DIV     = 100000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int DCLICK_TICKS = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_double,
    output logic o_hold
);

    // The hold counter must cover the largest threshold it is compared against.
    localparam int HMAX_A = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HMAX   = (HMAX_A > DCLICK_TICKS) ? HMAX_A : DCLICK_TICKS;
    localparam int HW     = $clog2(HMAX + 1);
    localparam int DW     = $clog2(TICK_DIV);

    localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);
    localparam logic [HW-1:0] HOLD_SAT    = '1;
`ifdef BTN_DCLICK_EN
    localparam logic [HW-1:0] DCLICK_LAST = HW'(DCLICK_TICKS - 1);
`endif

    typedef enum logic [2:0] {
        S_LOCKOUT   = 3'd0,
        S_IDLE      = 3'd1,
        S_PRESS     = 3'd2,
`ifdef BTN_DCLICK_EN
        S_LONG_HOLD = 3'd3,
        S_WAIT_2ND  = 3'd4,
        S_HOLD2     = 3'd5
`else
        S_LONG_HOLD = 3'd3
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_div_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic            w_tick;
    logic            w_transition;

    logic            r_short;
    logic            r_long;
    logic            r_repeat;
    logic            w_short_nxt;
    logic            w_long_nxt;
    logic            w_repeat_nxt;
`ifdef BTN_DCLICK_EN
    logic            r_double;
    logic            w_double_nxt;
`endif

    assign w_tick       = (r_div_cnt == DIV_LAST);
    assign w_transition = (w_state_nxt != r_state);

    // State register; reset lands in LOCKOUT so a button held through reset stays silent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOCKOUT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a release always wins over a coincident threshold tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOCKOUT: begin
                if (!i_btn) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (i_btn) w_state_nxt = S_PRESS;
            end
            S_PRESS: begin
                if (!i_btn) begin
`ifdef BTN_DCLICK_EN
                    w_state_nxt = S_WAIT_2ND;
`else
                    w_state_nxt = S_IDLE;
`endif
                end else if (w_tick && (r_hold_cnt == LONG_LAST)) begin
                    w_state_nxt = S_LONG_HOLD;
                end
            end
            S_LONG_HOLD: begin
                if (!i_btn) w_state_nxt = S_IDLE;
            end
`ifdef BTN_DCLICK_EN
            S_WAIT_2ND: begin
                if (i_btn) begin
                    w_state_nxt = S_HOLD2;
                end else if (w_tick && (r_hold_cnt == DCLICK_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD2: begin
                if (!i_btn) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_LOCKOUT;
        endcase
    end

    // Output decode: next value of each event pulse, plus the hold level from the current state.
    always_comb begin
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;
`ifdef BTN_DCLICK_EN
        w_double_nxt = 1'b0;
`endif
        o_hold       = (r_state == S_PRESS) || (r_state == S_LONG_HOLD);
        case (r_state)
            S_PRESS: begin
                if (!i_btn) begin
`ifndef BTN_DCLICK_EN
                    w_short_nxt = 1'b1;
`endif
                end else if (w_tick && (r_hold_cnt == LONG_LAST)) begin
                    w_long_nxt = 1'b1;
                end
            end
            S_LONG_HOLD: begin
                if (i_btn && w_tick && (r_hold_cnt == REPEAT_LAST)) begin
                    w_repeat_nxt = 1'b1;
                end
            end
`ifdef BTN_DCLICK_EN
            S_WAIT_2ND: begin
                if (i_btn) begin
                    w_double_nxt = 1'b1;
                end else if (w_tick && (r_hold_cnt == DCLICK_LAST)) begin
                    w_short_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_short_nxt = 1'b0;
            end
        endcase
    end

    // Tick prescaler; restarts on every state change so timing is measured from state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (w_transition || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Tick counter within a state; cleared on state entry and on each repeat, saturating otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
        end else if (w_transition || w_repeat_nxt) begin
            r_hold_cnt <= '0;
        end else if (w_tick && (r_hold_cnt != HOLD_SAT)) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
        end
    end

    // Registered event pulses; each is high for exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
        end else begin
            r_short  <= w_short_nxt;
            r_long   <= w_long_nxt;
            r_repeat <= w_repeat_nxt;
        end
    end

`ifdef BTN_DCLICK_EN
    // Registered double-click pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_double <= 1'b0;
        end else begin
            r_double <= w_double_nxt;
        end
    end
    assign o_double = r_double;
`else
    assign o_double = 1'b0;
`endif

    assign o_short  = r_short;
    assign o_long   = r_long;
    assign o_repeat = r_repeat;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: expected event pulses are queued with their absolute cycle and matched by a monitor.
// Latency: checks exact cycle of every pulse; o_hold and reset values checked directly.
// Backpressure: not applicable; stimulus is a per-cycle button level.
module tb_btn_event_decoder;

    localparam int TICK_DIV     = 4;
    localparam int LONG_TICKS   = 10;
    localparam int REPEAT_TICKS = 3;
    localparam int DCLICK_TICKS = 5;

    localparam int K_SHORT  = 0;
    localparam int K_LONG   = 1;
    localparam int K_REPEAT = 2;
    localparam int K_DOUBLE = 3;

    logic clk = 1'b0;
    logic rst;
    logic i_btn;
    logic o_short, o_long, o_repeat, o_double, o_hold;

    typedef struct {
        int kind;
        int cyc;
    } evt_t;

    evt_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   p;

    btn_event_decoder #(
        .TICK_DIV    (TICK_DIV),
        .LONG_TICKS  (LONG_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS),
        .DCLICK_TICKS(DCLICK_TICKS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (i_btn),
        .o_short (o_short),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_double(o_double),
        .o_hold  (o_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int kind, input int at);
        evt_t e;
        e.kind = kind;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Cycle at which o_short must appear for a release sampled in cycle rel.
    function automatic int short_at(input int rel);
`ifdef BTN_DCLICK_EN
        return rel + 1 + DCLICK_TICKS * TICK_DIV;
`else
        return rel + 1;
`endif
    endfunction

    // Hold i_btn at v for n cycles; enters and leaves aligned 1 time unit after a rising edge.
    task automatic drive(input logic v, input int n);
        i_btn = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every pulse seen must match the oldest expected event in kind and cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            logic [3:0] pulses;
            pulses = {o_double, o_repeat, o_long, o_short};
            if (pulses != 4'b0) begin
                chk("onehot_pulses", $countones(pulses), 1);
                for (int k = 0; k < 4; k++) begin
                    if (pulses[k]) begin
                        if (sb.size() == 0) begin
                            chk("spurious_evt_kind", k, -1);
                        end else begin
                            evt_t e;
                            e = sb.pop_front();
                            chk("evt_kind", k, e.kind);
                            chk("evt_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst   = 1'b0;
        i_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_short",  o_short,  0);
        chk("rst_long",   o_long,   0);
        chk("rst_repeat", o_repeat, 0);
        chk("rst_double", o_double, 0);
        chk("rst_hold",   o_hold,   0);
        rst = 1'b1;
        drive(1'b0, 3);

        // Short press: 20 cycles held, released inside PRESS.
        p = cyc;
        expect_evt(K_SHORT, short_at(p + 20));
        drive(1'b1, 20);
        chk("hold_in_press", o_hold, 1);
        drive(1'b0, 5);
        chk("hold_after_short", o_hold, 0);
        chk("long_after_short", o_long, 0);
        drive(1'b0, 30);
        chk("sb_drain_short", sb.size(), 0);

        // Long press with auto-repeat: 100 cycles; PRESS entry is p+1.
        p = cyc;
        expect_evt(K_LONG,   p + 1 + 40);
        expect_evt(K_REPEAT, p + 1 + 52);
        expect_evt(K_REPEAT, p + 1 + 64);
        expect_evt(K_REPEAT, p + 1 + 76);
        expect_evt(K_REPEAT, p + 1 + 88);
        drive(1'b1, 45);
        chk("hold_in_long", o_hold, 1);
        drive(1'b1, 55);
        drive(1'b0, 2);
        chk("hold_after_long", o_hold, 0);
        drive(1'b0, 30);
        chk("sb_drain_long", sb.size(), 0);

        // Release sampled exactly on the threshold tick (PRESS cycle 39): short only.
        p = cyc;
        expect_evt(K_SHORT, short_at(p + 40));
        drive(1'b1, 40);
        drive(1'b0, 35);
        chk("sb_drain_threshold", sb.size(), 0);

        // Reset during a long hold, then button held through reset release.
        p = cyc;
        expect_evt(K_LONG, p + 1 + 40);
        drive(1'b1, 46);
        chk("hold_before_rst", o_hold, 1);
        rst = 1'b0;
        #1;
        chk("midrst_hold",   o_hold,   0);
        chk("midrst_short",  o_short,  0);
        chk("midrst_long",   o_long,   0);
        chk("midrst_repeat", o_repeat, 0);
        chk("midrst_double", o_double, 0);
        @(posedge clk);
        #1;
        drive(1'b1, 3);
        rst = 1'b1;
        drive(1'b1, 30);
        chk("lockout_hold", o_hold, 0);
        drive(1'b0, 5);
        chk("sb_drain_lockout", sb.size(), 0);
        p = cyc;
        expect_evt(K_SHORT, short_at(p + 10));
        drive(1'b1, 10);
        drive(1'b0, 35);
        chk("sb_drain_after_lockout", sb.size(), 0);

`ifdef BTN_DCLICK_EN
        // Double click: press 8, gap 12, press 8.
        p = cyc;
        expect_evt(K_DOUBLE, p + 21);
        drive(1'b1, 8);
        drive(1'b0, 12);
        drive(1'b1, 8);
        drive(1'b0, 40);
        chk("sb_drain_double", sb.size(), 0);

        // Single click with a long gap: short after the double-click window.
        p = cyc;
        expect_evt(K_SHORT, short_at(p + 8));
        drive(1'b1, 8);
        drive(1'b0, 40);
        chk("sb_drain_dclick_short", sb.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
- Consumes a clean, synchronous button level (output of the debounce stage, held as a level) and classifies each press into single-cycle event pulses: short press, long press, auto-repeat while held and, optionally, double click.
- Sits between the debounce stage and the watch mode/setting controllers.
- Replaces ad-hoc per-controller hold counters with one shared, timed classifier per button.

Parameters:
- TICK_DIV, 100000, clk cycles per internal time tick (1 ms at 100 MHz); must be >= 2.
- LONG_TICKS, 1000, hold duration in ticks that qualifies as a long press; must be >= 1.
- REPEAT_TICKS, 200, period in ticks of o_repeat after o_long while held; must be >= 1.
- DCLICK_TICKS, 300, maximum release gap in ticks for a double click; used only with the optional feature.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-low reset.
- i_btn, input, 1, debounced button level, synchronous to clk, 1 = pressed.
- o_short, output, 1, one-cycle pulse: press released before the long threshold.
- o_long, output, 1, one-cycle pulse: hold reached LONG_TICKS.
- o_repeat, output, 1, one-cycle pulse every REPEAT_TICKS while still held after o_long.
- o_double, output, 1, one-cycle pulse on double click; tied 0 without the feature.
- o_hold, output, 1, level: high while the state is PRESS or LONG_HOLD.

Behaviour:
- Reset (rst = 0): state LOCKOUT; all counters cleared; all outputs 0.
- All outputs are registered. Pulses are exactly 1 cycle wide. At most one event pulse is high in any cycle.
- Tick prescaler:
  - div_cnt counts 0..TICK_DIV-1.
  - tick is high when div_cnt == TICK_DIV-1.
  - div_cnt is cleared on every state transition, so timing is measured from state entry.
- Hold counter (hold_cnt):
  - Increments on tick.
  - Cleared on entry to PRESS.
  - Reloaded to 0 on each o_repeat.
  - Width $clog2(max(LONG_TICKS, REPEAT_TICKS, DCLICK_TICKS)+1).
  - Never wraps; it saturates at its maximum.
- States:
  - LOCKOUT: entered from reset. Stays while i_btn = 1, so a button held through reset produces no event. i_btn = 0 -> IDLE.
  - IDLE: i_btn = 1 -> PRESS.
  - PRESS:
    - If i_btn = 0: o_short = 1 next cycle, then -> IDLE.
    - Else if tick and hold_cnt == LONG_TICKS-1: o_long = 1 next cycle, then -> LONG_HOLD.
    - Release has priority when it coincides with the threshold tick.
  - LONG_HOLD:
    - If i_btn = 0: -> IDLE with no event pulse.
    - Else if tick and hold_cnt == REPEAT_TICKS-1: o_repeat = 1 and hold_cnt = 0.
    - Release has priority.
- Timing: with cycle 0 defined as the first cycle in PRESS, o_long is high in cycle LONG_TICKS*TICK_DIV. The first o_repeat follows REPEAT_TICKS*TICK_DIV cycles later, then periodically.
- Release latency: o_short is high 1 cycle after the first cycle in which i_btn = 0 is sampled in PRESS.
- o_hold follows the registered state with no extra lag.
- rst asserted mid-press: outputs drop to 0 immediately (asynchronous). After release of rst, the state returns to LOCKOUT.

Optional Feature:
- Macro: BTN_DCLICK_EN.
- Defined:
  - PRESS release goes to WAIT_2ND instead of emitting o_short.
  - WAIT_2ND counts ticks.
  - If i_btn = 1 before hold_cnt reaches DCLICK_TICKS: o_double = 1 next cycle, then -> HOLD2. HOLD2 emits nothing and returns to IDLE on release.
  - On the timeout tick with i_btn still 0: o_short = 1 next cycle, then -> IDLE.
  - A press arriving on the timeout tick counts as double.
  - o_short latency becomes DCLICK_TICKS*TICK_DIV cycles after release.
- Undefined: WAIT_2ND and HOLD2 do not exist; o_double is constant 0; o_short behaves as in Behaviour.

Test Plan (TICK_DIV=4, LONG_TICKS=10, REPEAT_TICKS=3, DCLICK_TICKS=5):
- Hold i_btn=1 for 20 cycles, then release -> exactly one o_short, 1 cycle after the release sample; o_long, o_repeat and o_hold are 0 after it.
- Hold i_btn=1 for 100 cycles -> o_long in cycle 40 after PRESS entry; o_repeat at cycles 52, 64, 76, 88; no o_short on release.
- Release exactly on cycle 39 of PRESS (the threshold tick) -> o_short only; no o_long.
- Hold i_btn=1 through reset deassertion for 30 cycles, then release and press 10 cycles -> no event for the first press; one o_short for the second.
- Assert rst at cycle 45 during a long hold -> all outputs 0 the same cycle; state LOCKOUT; no o_repeat afterwards until a new press.
- BTN_DCLICK_EN: press 8, gap 12, press 8 -> one o_double, no o_short. Press 8, gap 25 -> o_short at 20 cycles after release; o_double = 0.
